// File: rtl/uart_frame_scheduler.sv
// One inverter switching period: fetch a sample over SPI, broadcast a 2-byte frame
// to every enabled module UART, wait for all of them to drain, then fire the shoot pulse.
module uart_frame_scheduler #(
  parameter int NUM_MODULES = 9,
  parameter int SHOOT_DELAY = 48,
  parameter int SHOOT_WIDTH = 24,
  parameter int TIMEOUT     = 24000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_MODULES-1:0]   module_mask,
  output logic                     spi_req,
  input  logic                     data_valid,
  input  logic [11:0]              sin_index,
  input  logic [3:0]               uart_id,
  output logic [NUM_MODULES-1:0]   start_tx,
  output logic [8*NUM_MODULES-1:0] data_to_tx,
  input  logic [NUM_MODULES-1:0]   tx_busy,
  output logic                     shoot,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     clear_err,
  output logic [15:0]              frame_count,
  output logic [3:0]               state_dbg
);

  // Handshakes are pulse/level pairs: spi_req is a 1-cycle request answered some cycles
  // later by a 1-cycle data_valid; start_tx[i] is a 1-cycle command, and lane i counts as
  // done only once tx_busy[i] has been seen high and has since returned low.

  localparam int MAX_AB  = (TIMEOUT > SHOOT_WIDTH) ? TIMEOUT : SHOOT_WIDTH;
  localparam int MAX_CNT = (MAX_AB > SHOOT_DELAY) ? MAX_AB : SHOOT_DELAY;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  // The WAIT1 exit cycle is the first delay cycle, so DELAY itself lasts SHOOT_DELAY-1.
  localparam logic [CW-1:0] DLY_LAST = CW'((SHOOT_DELAY > 1) ? SHOOT_DELAY - 2 : 0);
  localparam logic [CW-1:0] SHT_LAST = CW'(SHOOT_WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_DATA = 4'd1,
    S_SEND0     = 4'd2,
    S_WAIT0     = 4'd3,
    S_SEND1     = 4'd4,
    S_WAIT1     = 4'd5,
    S_DELAY     = 4'd6,
    S_SHOOT     = 4'd7,
    S_ABORT     = 4'd8
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [NUM_MODULES-1:0] mask_q;
  logic [NUM_MODULES-1:0] seen_q;
  logic [7:0]             sin_lo_q;
  logic [7:0]             byte_q;
  logic                   spi_req_q;
  logic                   tmo_q;
  logic [15:0]            frame_cnt_q;
  logic                   tx_done;
  logic                   counting;

  assign tx_done  = ((seen_q & mask_q) == mask_q) && ((tx_busy & mask_q) == '0);
  assign counting = (state_q == S_WAIT_DATA) || (state_q == S_WAIT0) ||
                    (state_q == S_WAIT1) || (state_q == S_DELAY) || (state_q == S_SHOOT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (data_valid)             state_d = (module_mask == '0) ? S_IDLE : S_SEND0;
        else if (!enable)           state_d = S_IDLE;
        else if (cnt_q == TMO_LAST) state_d = S_ABORT;
      end
      S_SEND0:     state_d = S_WAIT0;
      S_WAIT0: begin
        if (tx_done)                state_d = S_SEND1;
        else if (cnt_q == TMO_LAST) state_d = S_ABORT;
      end
      S_SEND1:     state_d = S_WAIT1;
      S_WAIT1: begin
        if (tx_done)                state_d = S_DELAY;
        else if (cnt_q == TMO_LAST) state_d = S_ABORT;
      end
      S_DELAY:     if (cnt_q == DLY_LAST) state_d = S_SHOOT;
      S_SHOOT:     if (cnt_q == SHT_LAST) state_d = S_IDLE;
      S_ABORT:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      seen_q      <= '0;
      sin_lo_q    <= '0;
      byte_q      <= '0;
      spi_req_q   <= 1'b0;
      tmo_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      spi_req_q <= (state_q == S_IDLE) && enable;

      if (state_d != state_q) cnt_q <= '0;
      else if (counting)      cnt_q <= cnt_q + CW'(1);

      // Byte0 is built straight from the inputs so it is on the lanes during SEND0.
      if (state_q == S_WAIT_DATA && data_valid) begin
        mask_q   <= module_mask;
        sin_lo_q <= sin_index[7:0];
        if (module_mask != '0) byte_q <= {uart_id, sin_index[11:8]};
      end
      if (state_q == S_WAIT0 && state_d == S_SEND1) byte_q <= sin_lo_q;

      if (state_q == S_SEND0 || state_q == S_SEND1)      seen_q <= '0;
      else if (state_q == S_WAIT0 || state_q == S_WAIT1) seen_q <= seen_q | tx_busy;

      if (state_d == S_ABORT && state_q != S_ABORT) tmo_q <= 1'b1;
      else if (clear_err)                           tmo_q <= 1'b0;

      if (state_q == S_SHOOT && state_d == S_IDLE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign spi_req     = spi_req_q;
  assign start_tx    = (state_q == S_SEND0 || state_q == S_SEND1) ? mask_q : '0;
  assign data_to_tx  = {NUM_MODULES{byte_q}};
  assign shoot       = (state_q == S_SHOOT);
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = tmo_q;
  assign frame_count = frame_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: SPI responder and uart_tx lane models run in a
// monitor process, the main process walks frame, mask, timeout, reset and wrap scenarios.
module tb_uart_frame_scheduler;
  localparam int NM = 9;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_WAIT1 = 4'd5, ST_ABORT = 4'd8;

  logic            clk = 1'b0, reset = 1'b0, enable = 1'b0, data_valid = 1'b0, clear_err = 1'b0;
  logic [NM-1:0]   module_mask = '0, tx_busy = '0;
  logic [11:0]     sin_index = '0;
  logic [3:0]      uart_id = '0;
  logic            spi_req, shoot, busy, timeout_err;
  logic [NM-1:0]   start_tx;
  logic [8*NM-1:0] data_to_tx;
  logic [15:0]     frame_count;
  logic [3:0]      state_dbg;

  uart_frame_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .module_mask(module_mask), .spi_req(spi_req),
    .data_valid(data_valid), .sin_index(sin_index), .uart_id(uart_id), .start_tx(start_tx),
    .data_to_tx(data_to_tx), .tx_busy(tx_busy), .shoot(shoot), .busy(busy),
    .timeout_err(timeout_err), .clear_err(clear_err), .frame_count(frame_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests_run = 0, fail_cnt = 0;
  logic [8*NM-1:0] exp_q[$];

  // monitor-owned bookkeeping
  int cyc = 0, spi_req_cnt = 0, dv_cnt = 0, shoot_rise_cnt = 0, shoot_rise_cyc = 0;
  int last_fall_cyc = 0, shoot_run = 0, last_width = 0, abort_len = 0, enter_cyc = 0;
  int resp_dly = 0;
  int tx_cnt[NM];
  int start_pulses[NM];
  logic shoot_prev = 1'b0;
  logic [3:0] prev_state = 4'd0;
  logic [NM-1:0] start_seen = '0;
  // main-owned controls
  logic spi_auto = 1'b1;
  logic [NM-1:0] stuck = '0;
  logic [11:0] resp_sin = '0;
  logic [3:0] resp_id = '0;
  int lane_base[NM];
  int sr0, sh0, dv0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string tag);
    int n = 0;
    while (state_dbg !== st && n < budget) begin tick(); n++; end
    check(tag, 72'(state_dbg === st), 72'(1));
  endtask

  task automatic wait_shoots(input int target, input int budget, input string tag);
    int n = 0;
    while (shoot_rise_cnt < target && n < budget) begin tick(); n++; end
    check(tag, 72'(shoot_rise_cnt >= target), 72'(1));
  endtask

  task automatic wait_dv(input int target, input int budget, input string tag);
    int n = 0;
    while (dv_cnt < target && n < budget) begin tick(); n++; end
    check(tag, 72'(dv_cnt >= target), 72'(1));
  endtask

  task automatic snap();
    for (int i = 0; i < NM; i++) lane_base[i] = start_pulses[i];
    sr0 = spi_req_cnt;
    sh0 = shoot_rise_cnt;
    dv0 = dv_cnt;
  endtask

  function automatic logic [NM-1:0] lanes_pulsed();
    logic [NM-1:0] v;
    for (int i = 0; i < NM; i++) v[i] = (start_pulses[i] != lane_base[i]);
    return v;
  endfunction

  // SPI responder, uart_tx lane models (10-cycle busy), scoreboard and pulse timing.
  initial begin
    logic [8*NM-1:0] exp_v;
    logic busy_new;
    for (int i = 0; i < NM; i++) begin tx_cnt[i] = 0; start_pulses[i] = 0; end
    forever begin
      @(posedge clk); #1;
      cyc++;
      data_valid = 1'b0;
      if (resp_dly > 0) begin
        resp_dly--;
        if (resp_dly == 0) begin
          data_valid = 1'b1; sin_index = resp_sin; uart_id = resp_id; dv_cnt++;
        end
      end else begin
        sin_index = 12'hFFF; uart_id = 4'hF;
      end
      if (spi_req) spi_req_cnt++;
      if (spi_req && spi_auto) resp_dly = 3;

      for (int i = 0; i < NM; i++) begin
        if (tx_cnt[i] > 0) tx_cnt[i]--;
        if (start_seen[i]) tx_cnt[i] = 10;
        start_seen[i] = start_tx[i];
        busy_new = stuck[i] | (tx_cnt[i] != 0);
        if (tx_busy[i] && !busy_new) last_fall_cyc = cyc;
        tx_busy[i] = busy_new;
        if (start_tx[i]) start_pulses[i]++;
      end

      if (start_tx != '0) begin
        if (exp_q.size() == 0) check("sb_unexpected_start", 72'(start_tx), 72'(0));
        else begin
          exp_v = exp_q.pop_front();
          check("sb_lane_bytes", data_to_tx, exp_v);
        end
      end

      if (shoot && !shoot_prev) begin
        shoot_rise_cnt++; shoot_rise_cyc = cyc; shoot_run = 1;
      end else if (shoot) shoot_run++;
      if (!shoot && shoot_prev) last_width = shoot_run;
      shoot_prev = shoot;

      if (state_dbg != prev_state) begin
        if (state_dbg == ST_ABORT) abort_len = cyc - enter_cyc;
        enter_cyc = cyc;
        prev_state = state_dbg;
      end
    end
  end

  initial begin
    // reset values, with enable already high
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_spi_req", 72'(spi_req), 72'(0));
    check("rst_start_tx", 72'(start_tx), 72'(0));
    check("rst_data_to_tx", data_to_tx, 72'(0));
    check("rst_shoot", 72'(shoot), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_timeout_err", 72'(timeout_err), 72'(0));
    check("rst_frame_count", 72'(frame_count), 72'(0));
    check("rst_state", 72'(state_dbg), 72'(ST_IDLE));
    enable = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (3) tick();
    check("idle_no_req", 72'(spi_req_cnt), 72'(0));

    // full-mask frame: 0xABC / id 5 -> 0x5A then 0xBC on all lanes
    resp_sin = 12'hABC; resp_id = 4'h5; module_mask = 9'h1FF;
    exp_q.push_back({NM{8'h5A}}); exp_q.push_back({NM{8'hBC}});
    snap();
    enable = 1'b1;
    wait_shoots(sh0 + 1, 2000, "f1_shoot_seen");
    enable = 1'b0;
    wait_state(ST_IDLE, 200, "f1_back_idle");
    check("f1_shoot_delay", 72'(shoot_rise_cyc - last_fall_cyc), 72'(48));
    check("f1_shoot_width", 72'(last_width), 72'(24));
    check("f1_frame_count", 72'(frame_count), 72'(1));
    check("f1_spi_req", 72'(spi_req_cnt - sr0), 72'(1));
    check("f1_lanes", 72'(lanes_pulsed()), 72'(9'h1FF));
    check("f1_sb_empty", 72'(exp_q.size()), 72'(0));

    // partial mask with unmasked lane 1 stuck busy; enable dropped in WAIT1
    resp_sin = 12'h123; resp_id = 4'h7; module_mask = 9'h005; stuck = 9'h002;
    exp_q.push_back({NM{8'h71}}); exp_q.push_back({NM{8'h23}});
    snap();
    enable = 1'b1;
    wait_state(ST_WAIT1, 500, "f2_reach_wait1");
    enable = 1'b0;
    wait_shoots(sh0 + 1, 500, "f2_shoot_seen");
    wait_state(ST_IDLE, 200, "f2_back_idle");
    repeat (20) tick();
    check("f2_stays_idle", 72'(state_dbg), 72'(ST_IDLE));
    check("f2_spi_req", 72'(spi_req_cnt - sr0), 72'(1));
    check("f2_lanes", 72'(lanes_pulsed()), 72'(9'h005));
    check("f2_frame_count", 72'(frame_count), 72'(2));
    stuck = '0;

    // all-zero mask at capture: no TX, no shoot, no count, lanes keep last byte
    resp_sin = 12'h0F0; resp_id = 4'h1; module_mask = '0;
    snap();
    enable = 1'b1;
    wait_dv(dv0 + 1, 100, "f3_dv_seen");
    enable = 1'b0;
    repeat (10) tick();
    check("f3_idle", 72'(state_dbg), 72'(ST_IDLE));
    check("f3_no_start", 72'(lanes_pulsed()), 72'(0));
    check("f3_no_shoot", 72'(shoot_rise_cnt - sh0), 72'(0));
    check("f3_frame_count", 72'(frame_count), 72'(2));
    check("f3_lanes_hold", data_to_tx, {NM{8'h23}});

    // masked lane 3 stuck busy: WAIT0 times out
    resp_sin = 12'h3C4; resp_id = 4'h6; module_mask = 9'h008; stuck = 9'h008;
    exp_q.push_back({NM{8'h63}});
    snap();
    enable = 1'b1;
    wait_dv(dv0 + 1, 100, "t1_dv_seen");
    enable = 1'b0;
    wait_state(ST_ABORT, 30000, "t1_abort");
    check("t1_abort_len", 72'(abort_len), 72'(24000));
    check("t1_err_set", 72'(timeout_err), 72'(1));
    repeat (5) tick();
    check("t1_err_sticky", 72'(timeout_err), 72'(1));
    check("t1_idle", 72'(state_dbg), 72'(ST_IDLE));
    check("t1_no_shoot", 72'(shoot_rise_cnt - sh0), 72'(0));
    check("t1_frame_count", 72'(frame_count), 72'(2));
    check("t1_lanes_hold", data_to_tx, {NM{8'h63}});
    stuck = '0;
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("t1_err_cleared", 72'(timeout_err), 72'(0));

    // SPI never answers: WAIT_DATA times out
    spi_auto = 1'b0;
    snap();
    enable = 1'b1;
    wait_state(ST_ABORT, 30000, "t2_abort");
    enable = 1'b0;
    check("t2_abort_len", 72'(abort_len), 72'(24000));
    check("t2_err_set", 72'(timeout_err), 72'(1));
    check("t2_frame_count", 72'(frame_count), 72'(2));
    check("t2_no_shoot", 72'(shoot_rise_cnt - sh0), 72'(0));
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("t2_err_cleared", 72'(timeout_err), 72'(0));
    spi_auto = 1'b1;
    tick();

    // reset asserted in shoot cycle 5, then released with enable high
    resp_sin = 12'h456; resp_id = 4'h9; module_mask = 9'h1FF;
    exp_q.push_back({NM{8'h94}}); exp_q.push_back({NM{8'h56}});
    snap();
    enable = 1'b1;
    wait_shoots(sh0 + 1, 2000, "r_shoot_seen");
    repeat (4) tick();
    check("r_shoot_before", 72'(shoot), 72'(1));
    reset = 1'b0;
    #1;
    check("r_shoot_cut", 72'(shoot), 72'(0));
    check("r_busy_cut", 72'(busy), 72'(0));
    check("r_state_idle", 72'(state_dbg), 72'(ST_IDLE));
    check("r_frame_count", 72'(frame_count), 72'(0));
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({NM{8'h94}}); exp_q.push_back({NM{8'h56}});
    end
    snap();
    @(negedge clk); reset = 1'b1;
    tick();
    check("r_first_spi_req", 72'(spi_req), 72'(1));

    // three back-to-back frames
    wait_shoots(sh0 + 3, 3000, "b2b_shoots_seen");
    enable = 1'b0;
    wait_state(ST_IDLE, 200, "b2b_back_idle");
    repeat (10) tick();
    check("b2b_spi_req", 72'(spi_req_cnt - sr0), 72'(3));
    check("b2b_shoots", 72'(shoot_rise_cnt - sh0), 72'(3));
    check("b2b_frame_count", 72'(frame_count), 72'(3));
    check("b2b_sb_empty", 72'(exp_q.size()), 72'(0));

    // frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    tick();
    check("wrap_preload", 72'(frame_count), 72'(16'hFFFF));
    resp_sin = 12'h800; resp_id = 4'hC;
    exp_q.push_back({NM{8'hC8}}); exp_q.push_back({NM{8'h00}});
    snap();
    enable = 1'b1;
    wait_shoots(sh0 + 1, 2000, "wrap_shoot_seen");
    enable = 1'b0;
    wait_state(ST_IDLE, 200, "wrap_back_idle");
    check("wrap_frame_count", 72'(frame_count), 72'(0));
    check("final_sb_empty", 72'(exp_q.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
